// File: rtl/div_unit.sv
// Iterative restoring divider for the EX stage (DIV/DIVU).
// It produces one quotient bit per cycle. The result is {remainder, quotient}.
module div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]         state, state_nxt;
    logic [2*WIDTH:0]   dividend, dividend_nxt;
    logic [WIDTH-1:0]   divisor, divisor_nxt;
    logic [CNT_W-1:0]   counter, counter_nxt;
    logic               neg_quot, neg_quot_nxt;
    logic               neg_rem, neg_rem_nxt;
    logic               ready_nxt;
    logic [2*WIDTH-1:0] result_nxt;

    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH:0]   step;
    logic [WIDTH-1:0]   quot, rem;

    // Magnitudes of the operands. The hardware iterates on unsigned values only.
    assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

    // Trial subtract of the shifted partial remainder. Bit WIDTH set means it went negative.
    assign trial = dividend[2*WIDTH:WIDTH] - {1'b0, divisor};
    assign step  = trial[WIDTH] ? {dividend[2*WIDTH-1:0], 1'b0}
                                : {trial[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};

    // Sign fix-up of the final step. The quotient is negated if the signs differ.
    // The remainder follows the dividend.
    assign quot = neg_quot ? (~step[WIDTH-1:0] + WIDTH'(1)) : step[WIDTH-1:0];
    assign rem  = neg_rem  ? (~step[2*WIDTH:WIDTH+1] + WIDTH'(1)) : step[2*WIDTH:WIDTH+1];

    // State register and registered outputs. Reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FREE;
            dividend <= '0;
            divisor  <= '0;
            counter  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            state    <= state_nxt;
            dividend <= dividend_nxt;
            divisor  <= divisor_nxt;
            counter  <= counter_nxt;
            neg_quot <= neg_quot_nxt;
            neg_rem  <= neg_rem_nxt;
            ready_o  <= ready_nxt;
            result_o <= result_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        dividend_nxt = dividend;
        divisor_nxt  = divisor;
        counter_nxt  = counter;
        neg_quot_nxt = neg_quot;
        neg_rem_nxt  = neg_rem;
        ready_nxt    = ready_o;
        result_nxt   = result_o;

        case (state)
            S_FREE: begin
                ready_nxt  = 1'b0;
                result_nxt = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_nxt = S_BYZERO;
                    end else begin
                        state_nxt    = S_ON;
                        dividend_nxt = {{WIDTH{1'b0}}, op1_abs, 1'b0};
                        divisor_nxt  = op2_abs;
                        counter_nxt  = '0;
                        neg_quot_nxt = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_nxt  = signed_div_i & opdata1_i[WIDTH-1];
                    end
                end
            end
            S_BYZERO: begin
                state_nxt  = S_END;
                result_nxt = '0;
            end
            S_ON: begin
                if (annul_i) begin
                    state_nxt = S_FREE;
                end else begin
                    dividend_nxt = step;
                    counter_nxt  = counter + CNT_W'(1);
                    if (counter == LAST_CNT) begin
                        state_nxt  = S_END;
                        result_nxt = {rem, quot};
                    end
                end
            end
            S_END: begin
                if (annul_i || !start_i) begin
                    state_nxt  = S_FREE;
                    ready_nxt  = 1'b0;
                    result_nxt = '0;
                end else begin
                    ready_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = S_FREE;
            end
        endcase
    end

endmodule
